// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between the pipeline MEM stage (master) and the data
// memory responder (slave).
//   req_rd, req_wr   load / store request this cycle
//   req_addr         byte address
//   req_wdata        store data, right-aligned
//   req_funct3       RISC-V width/sign code
//   rsp_rdata        extended load result
//   rsp_valid        rsp_rdata valid this cycle
//   busy             RAM clear in progress, requests ignored
//   misalign_err     one-cycle pulse after a bad access
//   err_addr         address of the most recent bad access
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_valid;
  logic              busy;
  logic              misalign_err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, req_funct3,
    input  rsp_rdata, rsp_valid, busy, misalign_err, err_addr
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, req_funct3,
    output rsp_rdata, rsp_valid, busy, misalign_err, err_addr
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Word-organised data RAM serving MEM-stage loads/stores with byte lanes,
// sign/zero-extended loads (one-cycle latency) and misalignment flagging.
// The RAM is cleared word by word after every reset before requests are taken.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   bus        dmem_responder_if.slave (request / response / status)
//   rd_count   accepted loads, saturating   (only with DMEM_ACCESS_CNT_EN)
//   wr_count   accepted stores, saturating  (only with DMEM_ACCESS_CNT_EN)
//
// Optional feature macro: DMEM_ACCESS_CNT_EN
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | clearing word[cnt] each cycle, busy=1, requests ignored
// ST_READY | serving requests until reset
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WIX_W = ADDR_W - 2;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    cnt_q;
  logic                busy_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                misalign_err_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                legal;
  logic                bad;
  logic                in_range;
  logic                do_store;
  logic [WIX_W-1:0]    word_idx;
  logic [IDX_W-1:0]    mem_idx;
  logic [1:0]          lane;
  logic [DATA_W-1:0]   rd_word;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_data;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wlane;

  always_comb begin
    accept   = (state_q == ST_READY);
    word_idx = bus.req_addr[ADDR_W-1:2];
    mem_idx  = word_idx[IDX_W-1:0];
    lane     = bus.req_addr[1:0];
    in_range = (32'(word_idx) < 32'(DEPTH));

    legal = 1'b0;
    case (bus.req_funct3)
      3'd0, 3'd4: legal = 1'b1;
      3'd1, 3'd5: legal = ~lane[0];
      3'd2:       legal = (lane == 2'b00);
      default:    legal = 1'b0;
    endcase
    bad = (bus.req_rd | bus.req_wr) & ~legal;

    // Out-of-range loads read as zero, so extension naturally yields 0.
    rd_word  = in_range ? mem_q[mem_idx] : '0;
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = '0;
    case (bus.req_funct3)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase

    // Store data is replicated across lanes; byte enables pick the target lanes.
    be    = 4'b0000;
    wlane = '0;
    case (bus.req_funct3[1:0])
      2'd0: begin
        be    = 4'b0001 << lane;
        wlane = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      2'd2: begin
        be    = 4'b1111;
        wlane = bus.req_wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = '0;
      end
    endcase

    do_store = accept & bus.req_wr & ~bad & in_range;
  end

  // RAM array: no reset, cleared by the INIT sweep instead. The read above
  // samples the old contents, giving read-before-write on a combined rd+wr.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[mem_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      busy_q         <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      misalign_err_q <= 1'b0;
      err_addr_q     <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        ST_READY: state_q <= ST_READY;
        default:  state_q <= ST_INIT;
      endcase

      rsp_valid_q    <= accept & bus.req_rd;
      misalign_err_q <= accept & bad;
      if (accept & bus.req_rd) rsp_rdata_q <= bad ? '0 : load_data;
      if (accept & bad)        err_addr_q  <= bus.req_addr;
    end
  end

  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.busy         = busy_q;
  assign bus.misalign_err = misalign_err_q;
  assign bus.err_addr     = err_addr_q;

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (accept & bus.req_rd & (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (accept & bus.req_wr & (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dmem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus ();

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(128)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: flat byte-addressed memory plus the last error address.
  logic [7:0] mbytes [512];
  logic [8:0] m_err_addr;

  function automatic void model_reset();
    for (int i = 0; i < 512; i++) mbytes[i] = 8'h00;
    m_err_addr = 9'h000;
  endfunction

  function automatic void model_access(input bit rd, input bit wr, input logic [8:0] a,
                                       input logic [31:0] wd, input logic [2:0] f3,
                                       output logic [31:0] rdata, output bit bad);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    bad = (rd || wr) && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (int'(a) % size) != 0);
    rdata = 32'h0;
    if (rd && !bad && int'(a) / 4 < 128) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mbytes[int'(a) + i];
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rdata = v;
    end
    if (wr && !bad && int'(a) / 4 < 128) begin
      for (int i = 0; i < size; i++) mbytes[int'(a) + i] = wd[8*i +: 8];
    end
    if (bad) m_err_addr = a;
  endfunction

  // Present one request for one clock, return at edge + 1.
  task automatic drive(input bit rd, input bit wr, input logic [8:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    bus.req_rd     = rd;
    bus.req_wr     = wr;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_rd     = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
  endtask

  task automatic test_reset();
    int cycles;
    int bad_seen;
    logic [31:0] exp;
    bit bad;
    clear_req();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
        bus.misalign_err !== 1'b0 || bus.err_addr !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_vals busy=%b valid=%b rdata=%h err=%b eaddr=%h want 1 0 0 0 0",
               bus.busy, bus.rsp_valid, bus.rsp_rdata, bus.misalign_err, bus.err_addr);
    end
    bus.req_rd     = 1'b1;
    bus.req_addr   = 9'h010;
    bus.req_funct3 = 3'd2;
    reset = 1'b1;
    cycles = 0;
    bad_seen = 0;
    while (bus.busy === 1'b1 && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.rsp_valid !== 1'b0 || bus.misalign_err !== 1'b0) bad_seen++;
    end
    clear_req();
    n_tests++;
    if (cycles !== 128) begin
      n_fail++;
      $display("FAIL init_len got %0d cycles want 128", cycles);
    end
    n_tests++;
    if (bad_seen !== 0) begin
      n_fail++;
      $display("FAIL init_ignore got %0d responses during busy want 0", bad_seen);
    end
    model_access(1, 0, 9'h010, 32'h0, 3'd2, exp, bad);
    drive(1, 0, 9'h010, 32'h0, 3'd2);
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL post_init_lw got valid=%b rdata=%h want 1 00000000", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_lanes();
    logic [8:0]  la [5] = '{9'h020, 9'h023, 9'h023, 9'h022, 9'h022};
    logic [2:0]  lf [5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] le [5] = '{32'h0000_0045, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1, 32'h0000_80F1};
    logic [31:0] exp;
    bit bad;
    model_access(0, 1, 9'h020, 32'h80F1_2345, 3'd2, exp, bad);
    drive(0, 1, 9'h020, 32'h80F1_2345, 3'd2);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_no_rsp got valid=%b want 0", bus.rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      model_access(1, 0, la[i], 32'h0, lf[i], exp, bad);
      drive(1, 0, la[i], 32'h0, lf[i]);
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== le[i]) begin
        n_fail++;
        $display("FAIL lanes[%0d] got valid=%b rdata=%h want 1 %h", i, bus.rsp_valid, bus.rsp_rdata, le[i]);
      end
    end
    clear_req();
  endtask

  task automatic test_partial_store();
    logic [31:0] exp;
    bit bad;
    model_access(0, 1, 9'h040, 32'h1122_3344, 3'd2, exp, bad);
    drive(0, 1, 9'h040, 32'h1122_3344, 3'd2);
    model_access(0, 1, 9'h041, 32'h0000_00AA, 3'd0, exp, bad);
    drive(0, 1, 9'h041, 32'h0000_00AA, 3'd0);
    model_access(0, 1, 9'h042, 32'h0000_BEEF, 3'd1, exp, bad);
    drive(0, 1, 9'h042, 32'h0000_BEEF, 3'd1);
    model_access(1, 0, 9'h040, 32'h0, 3'd2, exp, bad);
    drive(1, 0, 9'h040, 32'h0, 3'd2);
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hBEEF_AA44) begin
      n_fail++;
      $display("FAIL partial_store got valid=%b rdata=%h want 1 beefaa44", bus.rsp_valid, bus.rsp_rdata);
    end
    clear_req();
  endtask

  task automatic test_misalign();
    logic [31:0] exp;
    bit bad;
    model_access(0, 1, 9'h030, 32'hDEAD_BEEF, 3'd2, exp, bad);
    drive(0, 1, 9'h030, 32'hDEAD_BEEF, 3'd2);
    model_access(1, 0, 9'h031, 32'h0, 3'd1, exp, bad);
    drive(1, 0, 9'h031, 32'h0, 3'd1);
    n_tests++;
    if (bus.misalign_err !== 1'b1 || bus.err_addr !== 9'h031 ||
        bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_lh got err=%b eaddr=%h valid=%b rdata=%h want 1 031 1 0",
               bus.misalign_err, bus.err_addr, bus.rsp_valid, bus.rsp_rdata);
    end
    model_access(0, 1, 9'h032, 32'h1234_5678, 3'd2, exp, bad);
    drive(0, 1, 9'h032, 32'h1234_5678, 3'd2);
    n_tests++;
    if (bus.misalign_err !== 1'b1 || bus.err_addr !== 9'h032 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_sw got err=%b eaddr=%h valid=%b want 1 032 0",
               bus.misalign_err, bus.err_addr, bus.rsp_valid);
    end
    model_access(1, 0, 9'h030, 32'h0, 3'd2, exp, bad);
    drive(1, 0, 9'h030, 32'h0, 3'd2);
    n_tests++;
    if (bus.rsp_rdata !== 32'hDEAD_BEEF || bus.misalign_err !== 1'b0 || bus.err_addr !== 9'h032) begin
      n_fail++;
      $display("FAIL misalign_after got rdata=%h err=%b eaddr=%h want deadbeef 0 032",
               bus.rsp_rdata, bus.misalign_err, bus.err_addr);
    end
    clear_req();
  endtask

  task automatic test_rw_same();
    logic [31:0] exp;
    bit bad;
    model_access(1, 1, 9'h050, 32'hCAFE_F00D, 3'd2, exp, bad);
    drive(1, 1, 9'h050, 32'hCAFE_F00D, 3'd2);
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rw_old got valid=%b rdata=%h want 1 00000000", bus.rsp_valid, bus.rsp_rdata);
    end
    model_access(1, 0, 9'h050, 32'h0, 3'd2, exp, bad);
    drive(1, 0, 9'h050, 32'h0, 3'd2);
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL rw_new got valid=%b rdata=%h want 1 cafef00d", bus.rsp_valid, bus.rsp_rdata);
    end
    clear_req();
  endtask

  task automatic test_random();
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] illegal_f3 [3] = '{3'd3, 3'd6, 3'd7};
    logic [31:0] exp;
    bit bad;
    bit rd, wr;
    logic [8:0] a;
    logic [31:0] wd;
    logic [2:0] f3;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      a  = 9'($urandom_range(0, 127));
      wd = $urandom;
      f3 = ($urandom_range(0, 15) < 13) ? legal_f3[$urandom_range(0, 4)]
                                        : illegal_f3[$urandom_range(0, 2)];
      model_access(rd, wr, a, wd, f3, exp, bad);
      drive(rd, wr, a, wd, f3);
      n_tests++;
      if (bus.rsp_valid !== rd) begin
        n_fail++;
        $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.rsp_valid, rd);
      end
      if (rd) begin
        n_tests++;
        if (bus.rsp_rdata !== exp) begin
          n_fail++;
          $display("FAIL rnd_rdata[%0d] a=%h f3=%0d got %h want %h", i, a, f3, bus.rsp_rdata, exp);
        end
      end
      n_tests++;
      if (bus.misalign_err !== bad || bus.err_addr !== m_err_addr) begin
        n_fail++;
        $display("FAIL rnd_err[%0d] got err=%b eaddr=%h want %b %h",
                 i, bus.misalign_err, bus.err_addr, bad, m_err_addr);
      end
    end
    clear_req();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    bit bad;
    int cycles;
    for (int i = 0; i < 4; i++) begin
      model_access(1, 0, 9'h040, 32'h0, 3'd2, exp, bad);
      drive(1, 0, 9'h040, 32'h0, 3'd2);
    end
    #2;
    reset = 1'b0;
    #1;
    clear_req();
    model_reset();
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid got valid=%b busy=%b want 0 1", bus.rsp_valid, bus.busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    n_tests++;
    if (cycles !== 128) begin
      n_fail++;
      $display("FAIL reinit_len got %0d cycles want 128", cycles);
    end
`ifdef DMEM_ACCESS_CNT_EN
    n_tests++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_reset got rd=%0d wr=%0d want 0 0", rd_count, wr_count);
    end
`endif
    model_access(1, 0, 9'h040, 32'h0, 3'd2, exp, bad);
    drive(1, 0, 9'h040, 32'h0, 3'd2);
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL recleared got valid=%b rdata=%h want 1 00000000", bus.rsp_valid, bus.rsp_rdata);
    end
    model_access(0, 1, 9'h044, 32'h0102_0304, 3'd2, exp, bad);
    drive(0, 1, 9'h044, 32'h0102_0304, 3'd2);
    model_access(1, 0, 9'h044, 32'h0, 3'd0, exp, bad);
    drive(1, 0, 9'h044, 32'h0, 3'd0);
    n_tests++;
    if (bus.rsp_rdata !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL after_reinit_lb got %h want 00000004", bus.rsp_rdata);
    end
    model_access(0, 1, 9'h048, 32'h0000_0099, 3'd0, exp, bad);
    drive(0, 1, 9'h048, 32'h0000_0099, 3'd0);
    model_access(1, 0, 9'h046, 32'h0, 3'd5, exp, bad);
    drive(1, 0, 9'h046, 32'h0, 3'd5);
    n_tests++;
    if (bus.rsp_rdata !== 32'h0000_0102) begin
      n_fail++;
      $display("FAIL after_reinit_lhu got %h want 00000102", bus.rsp_rdata);
    end
`ifdef DMEM_ACCESS_CNT_EN
    n_tests++;
    if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
      n_fail++;
      $display("FAIL cnt_values got rd=%0d wr=%0d want 3 2", rd_count, wr_count);
    end
`endif
    clear_req();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_lanes();
    test_partial_store();
    test_misalign();
    test_rw_same();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
